// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory responder: access sizes and FSM states.
package riscv_mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational byte-lane logic: store merge, load extraction/extension, misalignment detection.
module mem_align_unit
    import riscv_mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    output logic [31:0] new_word_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] shifted;

    assign byte_sh = {offset_i, 3'b000};
    assign half_sh = {offset_i[1], 4'b0000};

    always_comb begin
        misaligned_o = 1'b0;
        new_word_o   = old_word_i;
        load_data_o  = 32'h0;
        shifted      = 32'h0;
        case (size_i)
            MEM_B: begin
                new_word_o[byte_sh +: 8] = wdata_i[7:0];
                shifted     = old_word_i >> byte_sh;
                load_data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_H: begin
                misaligned_o = offset_i[0];
                new_word_o[half_sh +: 16] = wdata_i[15:0];
                shifted     = old_word_i >> half_sh;
                load_data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            MEM_W: begin
                misaligned_o = |offset_i;
                new_word_o   = wdata_i;
                load_data_o  = old_word_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory on the MEM stage: stalls the pipeline for LATENCY+1 cycles per access
// and presents the extended load result in the DONE cycle.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        misaligned_err
);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [31:0]         read_data_q;
    logic                err_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic                store_q;
    logic [31:0]         mem_q [DEPTH_WORDS];

    logic                req;
    logic                accept;
    logic                access_now;
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         new_word;
    logic [31:0]         load_data;
    logic                misaligned;
    logic                unused_addr_bits;

    // Upper address bits are intentionally dropped so accesses wrap modulo the array size.
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign req        = mem_read | mem_write;
    assign accept     = (state_q == IDLE) && req;
    assign access_now = (state_q == BUSY) && (cnt_q == 4'd0);
    assign idx        = addr_q[ADDR_W+1:2];

    assign stall          = !reset && (accept || (state_q == BUSY));
    assign read_data      = read_data_q;
    assign misaligned_err = err_q;

    mem_align_unit u_align (
        .old_word_i   (mem_q[idx]),
        .wdata_i      (wdata_q),
        .size_i       (size_q),
        .offset_i     (addr_q[1:0]),
        .unsigned_i   (uns_q),
        .new_word_o   (new_word),
        .load_data_o  (load_data),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            read_data_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (req) begin
                        state_q <= BUSY;
                        cnt_q   <= 4'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q     <= DONE;
                        err_q       <= misaligned;
                        read_data_q <= (store_q || misaligned) ? 32'h0 : load_data;
                    end
                end
                DONE: begin
                    // The request still visible here belongs to the finished instruction.
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= write_data;
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
            store_q <= mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (access_now && store_q && !misaligned) begin
            mem_q[idx] <= new_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder with LATENCY=2.
module tb_data_mem_responder;
    import riscv_mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        stall;
    logic [31:0] read_data;
    logic        misaligned_err;

    int checks;
    int failures;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    data_mem_responder #(.DEPTH_WORDS(256), .ADDR_W(8), .LATENCY(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .addr           (addr),
        .write_data     (write_data),
        .stall          (stall),
        .read_data      (read_data),
        .misaligned_err (misaligned_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
        v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        mem_read = 1'b0; mem_write = 1'b0; mem_size = MEM_W; mem_unsigned = 1'b0;
        addr = 32'h0; write_data = 32'h0;
    endtask

    // Called at posedge+1; returns at posedge+1 after DONE with inputs cleared.
    task automatic access(input vec_t v, input string name);
        int  stall_cyc;
        bit  done;
        mem_read = v.rd; mem_write = v.wr; mem_size = v.size; mem_unsigned = v.uns;
        addr = v.addr; write_data = v.wdata;
        stall_cyc = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (i == 0) chk({name, "_err_idle"}, {31'h0, misaligned_err}, 32'h0);
            if (stall) stall_cyc++;
            else done = 1;
        end
        chk({name, "_done_reached"}, {31'h0, done}, 32'h1);
        chk({name, "_stall_cycles"}, stall_cyc, 32'd3);
        chk({name, "_rdata"}, read_data, v.exp_rdata);
        chk({name, "_err"}, {31'h0, misaligned_err}, {31'h0, v.exp_err});
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        vec_t v;
        logic [31:0] held;
        checks = 0;
        failures = 0;
        clear_inputs();
        reset = 1'b1;

        add(0,1,MEM_W,0,32'h10, 32'hDEADBEEF, 32'h0,        0);
        add(1,0,MEM_W,0,32'h10, 32'h0,        32'hDEADBEEF, 0);
        add(0,1,MEM_W,0,32'h20, 32'h11223344, 32'h0,        0);
        add(0,1,MEM_B,0,32'h21, 32'h123456AA, 32'h0,        0);
        add(1,0,MEM_W,0,32'h20, 32'h0,        32'h1122AA44, 0);
        add(1,0,MEM_B,0,32'h21, 32'h0,        32'hFFFFFFAA, 0);
        add(1,0,MEM_B,1,32'h21, 32'h0,        32'h000000AA, 0);
        add(0,1,MEM_W,0,32'h30, 32'h55667788, 32'h0,        0);
        add(0,1,MEM_H,0,32'h32, 32'hFFFF8001, 32'h0,        0);
        add(1,0,MEM_W,0,32'h30, 32'h0,        32'h80017788, 0);
        add(1,0,MEM_H,0,32'h32, 32'h0,        32'hFFFF8001, 0);
        add(1,0,MEM_H,1,32'h32, 32'h0,        32'h00008001, 0);
        add(0,1,MEM_W,0,32'h40, 32'h0A0B0C0D, 32'h0,        0);
        add(1,0,MEM_W,0,32'h42, 32'h0,        32'h0,        1);
        add(0,1,MEM_H,0,32'h41, 32'hFFFFFFFF, 32'h0,        1);
        add(0,1,2'b11,0,32'h40, 32'hFFFFFFFF, 32'h0,        1);
        add(1,0,MEM_W,0,32'h40, 32'h0,        32'h0A0B0C0D, 0);
        add(1,0,2'b11,0,32'h40, 32'h0,        32'h0,        1);
        add(0,1,MEM_W,0,32'h50, 32'hA5A5A5A5, 32'h0,        0);
        add(1,1,MEM_W,0,32'h60, 32'h13579BDF, 32'h0,        0);
        add(1,0,MEM_W,0,32'h60, 32'h0,        32'h13579BDF, 0);
        add(0,1,MEM_W,0,32'h400,32'hCAFEF00D, 32'h0,        0);
        add(1,0,MEM_W,0,32'h0,  32'h0,        32'hCAFEF00D, 0);
        add(1,0,MEM_B,0,32'h3,  32'h0,        32'hFFFFFFCA, 0);
        add(1,0,MEM_H,1,32'h0,  32'h0,        32'h0000F00D, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_rdata", read_data, 32'h0);
        chk("reset_err", {31'h0, misaligned_err}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Entries run back-to-back: each request appears in the IDLE cycle right after DONE.
        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i], $sformatf("vec%0d", i));
        end

        held = 32'h0000F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_stall", i), {31'h0, stall}, 32'h0);
            chk($sformatf("idle%0d_rdata_hold", i), read_data, held);
        end

        @(posedge clk);
        #1;
        mem_write = 1'b1; mem_size = MEM_W; addr = 32'h50; write_data = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_stall", {31'h0, stall}, 32'h0);
        chk("midreset_rdata", read_data, 32'h0);
        chk("midreset_err", {31'h0, misaligned_err}, 32'h0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        v.rd = 1; v.wr = 0; v.size = MEM_W; v.uns = 0; v.addr = 32'h50; v.wdata = 32'h0;
        v.exp_rdata = 32'hA5A5A5A5; v.exp_err = 0;
        access(v, "after_reset_lw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
